// File: rtl/acs_if.sv
// acs_if: symbol/metric bundle into an ACS and survivor bundle out.
// master drives in_valid/self_state/data_recv/BMin1/BMin2; slave returns BMout/decision/out_valid.
interface acs_if;
  logic       in_valid;
  logic [1:0] self_state;
  logic [1:0] data_recv;
  logic [6:0] BMin1;
  logic [6:0] BMin2;
  logic [6:0] BMout;
  logic       decision;
  logic       out_valid;
`ifdef ACS_SAT_FLAG_EN
  logic       sat_flag;
`endif

  modport master (
    output in_valid, self_state, data_recv,
    output BMin1, BMin2,
`ifdef ACS_SAT_FLAG_EN
    input  sat_flag,
`endif
    input  BMout, decision, out_valid
  );

  modport slave (
    input  in_valid, self_state, data_recv,
    input  BMin1, BMin2,
`ifdef ACS_SAT_FLAG_EN
    output sat_flag,
`endif
    output BMout, decision, out_valid
  );
endinterface

// File: rtl/acs.sv
// acs: add-compare-select for one state of a 4-state K=3 (7/5) Viterbi trellis.
// Ports: clk, rst_n (sync, active low), io (acs_if.slave); ACS_SAT_FLAG_EN adds io.sat_flag.
module acs (
  input  logic clk,
  input  logic rst_n,
  acs_if.slave io
);
  logic [1:0] exp1;
  logic [1:0] exp2;
  logic [1:0] x1;
  logic [1:0] x2;
  logic [1:0] bm1;
  logic [1:0] bm2;
  logic [7:0] cand1;
  logic [7:0] cand2;
  logic [7:0] win;
  logic       sel;
  logic       sat;
  logic [6:0] bm_nxt;

  always_comb begin
    exp1 = 2'b00;
    exp2 = 2'b11;
    unique case (io.self_state)
      2'b00: begin exp1 = 2'b00; exp2 = 2'b11; end
      2'b01: begin exp1 = 2'b10; exp2 = 2'b01; end
      2'b10: begin exp1 = 2'b11; exp2 = 2'b00; end
      2'b11: begin exp1 = 2'b01; exp2 = 2'b10; end
    endcase
  end

  assign x1  = io.data_recv ^ exp1;
  assign x2  = io.data_recv ^ exp2;
  assign bm1 = {1'b0, x1[1]} + {1'b0, x1[0]};
  assign bm2 = {1'b0, x2[1]} + {1'b0, x2[0]};

  // 8-bit sums so a 127 metric plus a branch cost still compares correctly
  assign cand1 = {1'b0, io.BMin1} + {6'b0, bm1};
  assign cand2 = {1'b0, io.BMin2} + {6'b0, bm2};

  assign sel    = cand2 < cand1;
  assign win    = sel ? cand2 : cand1;
  assign sat    = win[7];
  assign bm_nxt = sat ? 7'h7f : win[6:0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      io.BMout     <= 7'd0;
      io.decision  <= 1'b0;
      io.out_valid <= 1'b0;
`ifdef ACS_SAT_FLAG_EN
      io.sat_flag  <= 1'b0;
`endif
    end else begin
      io.out_valid <= io.in_valid;
      if (io.in_valid) begin
        io.BMout    <= bm_nxt;
        io.decision <= sel;
`ifdef ACS_SAT_FLAG_EN
        io.sat_flag <= sat;
`endif
      end
    end
  end
endmodule

// File: tb/tb_acs.sv
// tb_acs: scoreboard bench for acs.
// Drives on negedge, compares #1 after posedge against a trellis model.
module tb_acs;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_err = 0;

  acs_if io ();

  acs dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (io.slave)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [6:0] bm;
    logic       dec;
    logic       sat;
  } exp_t;

  exp_t q[$];
  exp_t last;

  task automatic check(input string tag,
                       input int obs,
                       input int exp_v);
    n_chk++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d",
               tag, obs, exp_v);
    end
  endtask

  // codeword from shift-register taps:
  // c0 = u^a^b (g=111), c1 = u^b (g=101)
  function automatic logic [1:0] cw(
    input logic u, input logic a, input logic b);
    return {u ^ a ^ b, u ^ b};
  endfunction

  function automatic exp_t model(
    input logic [1:0] st, input logic [1:0] rx,
    input logic [6:0] m1, input logic [6:0] m2);
    exp_t r;
    int c1, c2, w;
    c1 = int'(m1) + $countones(rx ^ cw(st[1], st[0], 1'b0));
    c2 = int'(m2) + $countones(rx ^ cw(st[1], st[0], 1'b1));
    r.dec = (c2 < c1);
    w = r.dec ? c2 : c1;
    r.sat = (w > 127);
    r.bm = r.sat ? 7'd127 : w[6:0];
    return r;
  endfunction

  task automatic compare_out(input string tag);
    exp_t e;
    if (q.size() == 0) begin
      check({tag, "_sb_empty"}, 0, 1);
      return;
    end
    e = q.pop_front();
    last = e;
    check({tag, "_bm"}, int'(io.BMout), int'(e.bm));
    check({tag, "_dec"}, int'(io.decision), int'(e.dec));
    check({tag, "_ov"}, int'(io.out_valid), 1);
`ifdef ACS_SAT_FLAG_EN
    check({tag, "_sat"}, int'(io.sat_flag), int'(e.sat));
`endif
  endtask

  task automatic drive(input logic [1:0] st,
                       input logic [1:0] rx,
                       input logic [6:0] m1,
                       input logic [6:0] m2);
    @(negedge clk);
    io.in_valid   = 1'b1;
    io.self_state = st;
    io.data_recv  = rx;
    io.BMin1      = m1;
    io.BMin2      = m2;
    q.push_back(model(st, rx, m1, m2));
  endtask

  task automatic one(input string tag,
                     input logic [1:0] st,
                     input logic [1:0] rx,
                     input logic [6:0] m1,
                     input logic [6:0] m2);
    drive(st, rx, m1, m2);
    @(posedge clk);
    #1;
    compare_out(tag);
  endtask

  initial begin
    io.in_valid   = 1'b0;
    io.self_state = 2'b00;
    io.data_recv  = 2'b00;
    io.BMin1      = 7'd0;
    io.BMin2      = 7'd0;
    last          = '0;

    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_bm", int'(io.BMout), 0);
    check("rst_dec", int'(io.decision), 0);
    check("rst_ov", int'(io.out_valid), 0);
`ifdef ACS_SAT_FLAG_EN
    check("rst_sat", int'(io.sat_flag), 0);
`endif

    one("tie",   2'b00, 2'b00, 7'd5,   7'd3);
    one("path2", 2'b01, 2'b10, 7'd10,  7'd4);
    one("path1", 2'b10, 2'b11, 7'd20,  7'd19);
    one("sat",   2'b11, 2'b00, 7'd127, 7'd127);

    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      io.in_valid   = 1'b0;
      io.self_state = 2'($urandom);
      io.data_recv  = 2'($urandom);
      io.BMin1      = 7'($urandom);
      io.BMin2      = 7'($urandom);
      @(posedge clk);
      #1;
      check("hold_bm", int'(io.BMout), int'(last.bm));
      check("hold_dec", int'(io.decision), int'(last.dec));
      check("hold_ov", int'(io.out_valid), 0);
`ifdef ACS_SAT_FLAG_EN
      check("hold_sat", int'(io.sat_flag), int'(last.sat));
`endif
    end

    for (int i = 0; i < 64; i++) begin
      drive(2'(i), 2'($urandom),
            (i % 8 == 0) ? 7'd127 - 7'($urandom_range(0, 1))
                         : 7'($urandom),
            (i % 8 == 0) ? 7'd127 - 7'($urandom_range(0, 1))
                         : 7'($urandom));
      @(posedge clk);
      #1;
      compare_out("b2b");
    end

    @(negedge clk);
    rst_n       = 1'b0;
    io.in_valid = 1'b1;
    io.BMin1    = 7'd50;
    io.BMin2    = 7'd60;
    @(posedge clk);
    #1;
    check("rstpri_bm", int'(io.BMout), 0);
    check("rstpri_dec", int'(io.decision), 0);
    check("rstpri_ov", int'(io.out_valid), 0);
    @(negedge clk);
    rst_n       = 1'b1;
    io.in_valid = 1'b0;

    check("sb_drain", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end
endmodule
